fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding instruction fetch with decode handshake,
//             flush/redirect handling, drain of abandoned requests and a
//             sticky memory-timeout error.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int TIMEOUT = 15  // max cycles waiting for imem_ack (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  // Last wait-count value tolerated before the request is declared dead.
  localparam logic [3:0] C_WAIT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [3:0]  r_wait;

  logic        w_in_req;
  logic        w_in_drain;
  logic        w_wait_expired;

  assign w_in_req       = (r_state == S_REQ);
  assign w_in_drain     = (r_state == S_DRAIN);
  assign w_wait_expired = (r_wait == C_WAIT_LAST);

  // Memory request is a pure function of the registered state, so the
  // address and strobe never glitch with same-cycle inputs.
  assign imem_req    = w_in_req | w_in_drain;
  assign imem_addr   = r_req_addr;

  // PC advance fires only on a request that completes and is kept.
  assign pc_write    = w_in_req & imem_ack & ~flush & ~reset;
  assign pc_next     = r_req_addr + 32'd1;

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = (r_state == S_ERR);

  // Fetch sequencing: issue, wait, hand off to decode, drain or lock up.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_req_addr    <= 32'd0;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_wait        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush) begin
            r_req_addr <= pc;
            r_wait     <= 4'd0;
            r_state    <= S_REQ;
          end
        end

        S_REQ: begin
          if (imem_ack) begin
            if (!flush) begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= r_req_addr;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end else begin
              // Data arrived with the redirect: drop it.
              r_state <= S_IDLE;
            end
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
          end else if (flush) begin
            // Request is still outstanding; keep it on the bus until it
            // completes so only one request is ever in flight.
            r_wait  <= 4'd0;
            r_state <= S_DRAIN;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end

        S_DRAIN: begin
          if (imem_ack) begin
            r_state <= S_IDLE;
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end

        S_HOLD: begin
          if (flush) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else if (instr_ready) begin
            // Accepted: fetch the next word straight away.
            r_instr_valid <= 1'b0;
            r_req_addr    <= pc;
            r_wait        <= 4'd0;
            r_state       <= S_REQ;
          end
        end

        S_ERR: begin
          r_state <= S_ERR;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed and randomized checks of fetch_unit against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_write    (pc_write),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: one outstanding transaction, an optional held
  // instruction, and a sticky error flag.
  bit          m_known = 1'b0;
  bit          m_busy;     // a memory transaction is outstanding
  bit          m_discard;  // its data will be thrown away
  bit          m_have;     // an instruction is offered to decode
  bit          m_err;
  int          m_waits;
  logic [31:0] m_addr;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_known = 1'b1; m_busy = 1'b0; m_discard = 1'b0; m_have = 1'b0;
      m_err = 1'b0; m_waits = 0; m_addr = '0; m_instr = '0; m_ipc = '0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_busy) begin
      if (imem_ack) begin
        m_busy = 1'b0;
        if (!m_discard && !flush) begin
          m_have = 1'b1; m_instr = imem_rdata; m_ipc = m_addr;
        end
      end else if (m_waits + 1 == TIMEOUT) begin
        m_busy = 1'b0; m_err = 1'b1;
      end else if (flush && !m_discard) begin
        m_discard = 1'b1; m_waits = 0;
      end else begin
        m_waits++;
      end
    end else if (m_have) begin
      if (flush) m_have = 1'b0;
      else if (instr_ready) begin
        m_have = 1'b0; m_busy = 1'b1; m_discard = 1'b0; m_addr = pc; m_waits = 0;
      end
    end else if (!flush) begin
      m_busy = 1'b1; m_discard = 1'b0; m_addr = pc; m_waits = 0;
    end
  endtask

  // Let combinational outputs settle after inputs change, then compare.
  task automatic settle();
    logic exp_pcw;
    #1;
    if (m_known) begin
      exp_pcw = m_busy & ~m_discard & imem_ack & ~flush & ~reset;
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
      if (m_busy) chk("imem_addr", imem_addr, m_addr);
      chk("pc_write", {31'd0, pc_write}, {31'd0, exp_pcw});
      if (exp_pcw) chk("pc_next", pc_next, m_addr + 32'd1);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic a,
                       input logic [31:0] d, input logic f, input logic rdy);
    reset = r; pc = p; imem_ack = a; imem_rdata = d; flush = f; instr_ready = rdy;
  endtask

  initial begin : main
    int pulses;
    drive(1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    step();

    // Reset state, with ack and flush asserted to show reset dominates.
    drive(1'b1, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    settle();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    advance();

    // First fetch after reset release from pc=107.
    drive(1'b0, 32'd107, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd107, 1'b1, 32'h8C01_0004, 1'b0, 1'b0);
    settle();
    chk("c2_addr", imem_addr, 32'd107);
    chk("c2_pcw", {31'd0, pc_write}, 32'd1);
    chk("c2_pcnext", pc_next, 32'd108);
    advance();
    drive(1'b0, 32'd108, 1'b0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("c3_instr", instr, 32'h8C01_0004);
    chk("c3_ipc", instr_pc, 32'd107);
    chk("c3_valid", {31'd0, instr_valid}, 32'd1);
    advance();

    // Decode stalls, then a fetch with three wait states.
    for (int i = 0; i < 3; i++) step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3); imem_rdata = 32'h1234_5678;
      settle();
      chk("ws_addr", imem_addr, 32'd108);
      pulses += int'(pc_write);
      advance();
    end
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ws_hold", instr, 32'h1234_5678);
      pulses += int'(pc_write);
      advance();
    end
    chk("ws_pulses", pulses, 32'd1);

    // Flush while waiting: drain the outstanding request, refetch from 200.
    drive(1'b0, 32'd300, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'd300, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd200, 1'b0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("dr_req", {31'd0, imem_req}, 32'd1);
    chk("dr_addr", imem_addr, 32'd300);
    advance();
    drive(1'b0, 32'd200, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0);
    settle();
    chk("dr_pcw", {31'd0, pc_write}, 32'd0);
    advance();
    imem_ack = 1'b0;
    step();
    drive(1'b0, 32'd200, 1'b1, 32'h0000_00C8, 1'b0, 1'b0);
    settle();
    chk("dr_new_addr", imem_addr, 32'd200);
    advance();

    // Flush coincident with ack: nothing delivered, refetch from 500.
    drive(1'b0, 32'd400, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'd500, 1'b1, 32'h5555_5555, 1'b1, 1'b0);
    settle();
    chk("fa_pcw", {31'd0, pc_write}, 32'd0);
    advance();
    drive(1'b0, 32'd500, 1'b0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("fa_valid", {31'd0, instr_valid}, 32'd0);
    advance();
    drive(1'b0, 32'd500, 1'b1, 32'h0000_01F4, 1'b0, 1'b0);
    settle();
    chk("fa_addr", imem_addr, 32'd500);
    advance();

    // Address wrap.
    drive(1'b0, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'd0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    settle();
    chk("wrap_pcnext", pc_next, 32'd0);
    advance();

    // Memory never answers: error after TIMEOUT request cycles.
    drive(1'b0, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1);
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      chk("to_err_early", {31'd0, fetch_err}, 32'd0);
      advance();
    end
    settle();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    advance();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("to_cleared", {31'd0, fetch_err}, 32'd0);
    advance();

    // Randomized traffic, including resets landing mid-request.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 60) == 0, $urandom, ($urandom % 3) != 0, $urandom,
            ($urandom % 8) == 0, ($urandom % 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
